locker_indicator: RTL and testbench
===================================

// Module: locker_indicator
// PURPOSE
//  Downstream of the serial locker FSM. Consumes its Unlock/Err/alert flags and its 7-seg pattern.
//  Turns level flags into timed LED pulses and a blinking alarm/buzzer.
//  Counts failed attempts and multiplexes a 2-digit 7-seg: locker pattern plus error count.
// PARAMETERS
//  UNLOCK_HOLD  100_000_000  cycles led_unlock stays lit after an Unlock rise (>=1)
//  ERR_HOLD     50_000_000   cycles led_err stays lit after an Err rise (>=1)
//  BLINK_HALF   25_000_000   half-period, in cycles, of the alarm buzzer/LED square wave (>=1)
//  SCAN_CYCLES  100_000      cycles each 7-seg digit is driven before switching (>=1)
// PORTS
//  CLK         in   1  system clock, all state on rising edge
//  RST         in   1  asynchronous, active-high reset
//  Unlock      in   1  locker unlock flag (level)
//  Err         in   1  locker error flag (level)
//  alert       in   1  locker alarm flag (level)
//  digits      in   7  locker 7-seg pattern, active-high, bit0=a..bit6=g
//  led_unlock  out  1  unlock indicator
//  led_err     out  1  error indicator
//  buzzer      out  1  alarm drive
//  seg         out  7  7-seg segments, same encoding as digits
//  an          out  2  digit enables, active-low one-hot; an[0]=locker digit, an[1]=err count
//  err_cnt     out  4  failed-attempt count, 0..9 saturating
// BEHAVIOUR
//  Reset (async, RST=1):
//   - state=IDLE; all counters=0; edge-history regs=0.
//   - Outputs: led_unlock=0, led_err=0, buzzer=0, err_cnt=0, an=2'b10, seg=digits.
//   - RST mid-operation aborts any hold/blink immediately.
//  Edge detect:
//   - prev_* registers sample Unlock and Err each edge.
//   - A rise is detected at edge N when the input is 1 at N and was 0 at N-1.
//   - A flag already high when RST releases is not a rise.
//  FSM states: IDLE, OPEN, FAULT, ALARM. Priority of entry conditions: alert > Unlock-rise > Err-rise.
//   - any state, alert==1 -> ALARM. Blink counter cleared; buzzer=1 on entry.
//   - IDLE/FAULT/OPEN, Unlock rise -> OPEN. Hold counter loads UNLOCK_HOLD; a re-rise retriggers.
//   - IDLE/OPEN/FAULT, Err rise (no Unlock rise) -> FAULT. Hold counter loads ERR_HOLD; a re-rise retriggers.
//   - OPEN/FAULT: hold counter decrements each cycle; reaching 0 -> IDLE.
//   - ALARM, alert==0:
//     - Unlock==1 (level) -> OPEN with fresh UNLOCK_HOLD.
//     - otherwise -> IDLE.
//  Outputs, registered from state:
//   - OPEN: led_unlock=1, others 0.
//   - FAULT: led_err=1, others 0.
//   - ALARM: buzzer toggles every BLINK_HALF cycles; led_err=buzzer; led_unlock=0.
//   - IDLE: all 0.
//   - An entry event at edge N drives the output from edge N; OPEN lasts exactly UNLOCK_HOLD cycles.
//  err_cnt:
//   - Increments by 1 on every Err rise, in any state; saturates at 9.
//   - Cleared to 0 on an Unlock rise.
//   - Same-edge Unlock rise and Err rise: clear wins, FSM -> OPEN.
//  Display scan:
//   - Scan counter wraps at SCAN_CYCLES-1, then toggles the active digit.
//   - an[0] low: seg=digits (registered).
//   - an[1] low: seg=seg7 encoding of err_cnt.
//   - Exactly one an bit is low at all times.
//  All counters are sized $clog2(param+1). No wrap is visible except the scan counter.
// STRUCTURE
//  locker_pkg:
//   - typedef enum logic[1:0] {IDLE,OPEN,FAULT,ALARM} ind_state_t.
//   - SEG_* constants for 0-9, ERR_CNT_MAX=4'd9.
//  Sub-module seg7_encode: 4-bit value -> 7-bit pattern, combinational; values >9 give blank (7'h00).
//  Top holds the FSM, edge detect, hold/blink/scan counters and output registers.
// TESTING (bench overrides UNLOCK_HOLD=4, ERR_HOLD=3, BLINK_HALF=2, SCAN_CYCLES=2)
//  1. RST pulse with Unlock=1 held -> all outputs 0, err_cnt=0, an=2'b10; no OPEN after release.
//  2. Unlock 0->1 at edge N -> led_unlock=1 for edges N..N+3, 0 at N+4; err_cnt cleared.
//  3. Three Err rises separated by drops -> err_cnt=3; led_err high 3 cycles after each; an[1] low shows SEG_3.
//  4. alert=1 for 10 cycles -> buzzer pattern 1,1,0,0,1,1,0,0,...; led_err tracks buzzer; alert->0 with Unlock=1 -> OPEN for 4 cycles, buzzer=0.
//  5. Unlock and Err rise on the same edge -> OPEN, err_cnt=0, led_err=0.
//  6. Ten Err rises -> err_cnt saturates at 9; RST asserted mid-FAULT -> led_err=0 immediately, err_cnt=0.

Source files
------------

// File: rtl/locker_pkg.sv
// Shared types and constants for the locker indicator block.
// State encoding, 7-seg glyphs and the error-count ceiling.
package locker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        FAULT = 2'd2,
        ALARM = 2'd3
    } ind_state_t;

    // Segment order is bit0=a .. bit6=g, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] ERR_CNT_MAX = 4'd9;

endpackage

// File: rtl/locker_indicator_seg7_encode.sv
// Decimal digit to 7-seg pattern.
// Anything above 9 is shown blank.
module seg7_encode
    import locker_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    // Pure lookup; out-of-range values blank the digit.
    always_comb begin
        pattern = SEG_BLANK;
        unique case (value)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/locker_indicator.sv
// Indicator stage after the locker FSM: timed LEDs, blinking alarm,
// failed-attempt counter and a two-digit multiplexed 7-seg display.
module locker_indicator
    import locker_pkg::*;
#(
    parameter int UNLOCK_HOLD = 100_000_000,
    parameter int ERR_HOLD    = 50_000_000,
    parameter int BLINK_HALF  = 25_000_000,
    parameter int SCAN_CYCLES = 100_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Unlock,
    input  logic       Err,
    input  logic       alert,
    input  logic [6:0] digits,
    output logic       led_unlock,
    output logic       led_err,
    output logic       buzzer,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] err_cnt
);

    localparam int HOLD_MAX = (UNLOCK_HOLD > ERR_HOLD) ? UNLOCK_HOLD : ERR_HOLD;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int SW = $clog2(SCAN_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_UNLOCK = HW'(UNLOCK_HOLD);
    localparam logic [HW-1:0] HOLD_ERR    = HW'(ERR_HOLD);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);
    localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_CYCLES - 1);

    ind_state_t    state, state_d;
    logic [HW-1:0] hold, hold_d;
    logic [BW-1:0] blink, blink_d;
    logic [SW-1:0] scan;
    logic          scan_sel;
    logic          buzzer_d, led_unlock_d, led_err_d;
    logic          primed, prev_unlock, prev_err;
    logic          unlock_rise, err_rise;
    logic [6:0]    cnt_pattern;

    // The first edge after reset only primes the history, so a flag
    // that was already high during reset never counts as a rise.
    assign unlock_rise = primed & Unlock & ~prev_unlock;
    assign err_rise    = primed & Err & ~prev_err;

    // Edge-history registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            primed      <= 1'b0;
            prev_unlock <= 1'b0;
            prev_err    <= 1'b0;
        end else begin
            primed      <= 1'b1;
            prev_unlock <= Unlock;
            prev_err    <= Err;
        end
    end

    // Next state, counters and output values; alert beats Unlock beats Err.
    always_comb begin
        state_d  = state;
        hold_d   = hold;
        blink_d  = blink;
        buzzer_d = 1'b0;
        if (alert) begin
            state_d = ALARM;
            if (state != ALARM) begin
                blink_d  = '0;
                buzzer_d = 1'b1;
            end else if (blink == BLINK_LAST) begin
                blink_d  = '0;
                buzzer_d = ~buzzer;
            end else begin
                blink_d  = blink + 1'b1;
                buzzer_d = buzzer;
            end
        end else if (state == ALARM) begin
            if (Unlock) begin
                state_d = OPEN;
                hold_d  = HOLD_UNLOCK;
            end else begin
                state_d = IDLE;
                hold_d  = '0;
            end
        end else if (unlock_rise) begin
            state_d = OPEN;
            hold_d  = HOLD_UNLOCK;
        end else if (err_rise) begin
            state_d = FAULT;
            hold_d  = HOLD_ERR;
        end else if (state == OPEN || state == FAULT) begin
            if (hold <= HOLD_LAST) begin
                state_d = IDLE;
                hold_d  = '0;
            end else begin
                hold_d = hold - 1'b1;
            end
        end
        led_unlock_d = (state_d == OPEN);
        led_err_d    = (state_d == FAULT) | ((state_d == ALARM) & buzzer_d);
    end

    // State, counters and registered indicator outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            hold       <= '0;
            blink      <= '0;
            buzzer     <= 1'b0;
            led_unlock <= 1'b0;
            led_err    <= 1'b0;
        end else begin
            state      <= state_d;
            hold       <= hold_d;
            blink      <= blink_d;
            buzzer     <= buzzer_d;
            led_unlock <= led_unlock_d;
            led_err    <= led_err_d;
        end
    end

    // Failed-attempt count: an unlock clears it, even on a shared edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt <= '0;
        end else if (unlock_rise) begin
            err_cnt <= '0;
        end else if (err_rise && err_cnt != ERR_CNT_MAX) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // Digit scan: hold each digit SCAN_CYCLES cycles, then swap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan     <= '0;
            scan_sel <= 1'b0;
        end else if (scan == SCAN_LAST) begin
            scan     <= '0;
            scan_sel <= ~scan_sel;
        end else begin
            scan <= scan + 1'b1;
        end
    end

    seg7_encode u_seg7 (
        .value   (err_cnt),
        .pattern (cnt_pattern)
    );

    assign an  = scan_sel ? 2'b01 : 2'b10;
    assign seg = scan_sel ? cnt_pattern : digits;

endmodule

// File: tb/tb_locker_indicator.sv
// Directed bench for locker_indicator with short hold/blink/scan times.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_locker_indicator;

    logic       CLK;
    logic       RST;
    logic       Unlock;
    logic       Err;
    logic       alert;
    logic [6:0] digits;
    logic       led_unlock;
    logic       led_err;
    logic       buzzer;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] err_cnt;

    int tests;
    int fails;

    locker_indicator #(
        .UNLOCK_HOLD (4),
        .ERR_HOLD    (3),
        .BLINK_HALF  (2),
        .SCAN_CYCLES (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Unlock     (Unlock),
        .Err        (Err),
        .alert      (alert),
        .digits     (digits),
        .led_unlock (led_unlock),
        .led_err    (led_err),
        .buzzer     (buzzer),
        .seg        (seg),
        .an         (an),
        .err_cnt    (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Unlock = 1'b1;
        Err    = 1'b0;
        alert  = 1'b0;
        digits = 7'h5A;
        RST    = 1'b1;
        step();
        step();
        tests++;
        if ({led_unlock, led_err, buzzer} !== 3'b000) begin
            fails++;
            $display("FAIL reset_leds: got %b want 000", {led_unlock, led_err, buzzer});
        end
        tests++;
        if (err_cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
        tests++;
        if (an !== 2'b10) begin
            fails++;
            $display("FAIL reset_an: got %b want 10", an);
        end
        tests++;
        if (seg !== 7'h5A) begin
            fails++;
            $display("FAIL reset_seg: got %h want 5a", seg);
        end
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (led_unlock !== 1'b0) begin
                fails++;
                $display("FAIL held_unlock_no_open[%0d]: got %b want 0", i, led_unlock);
            end
        end
        Unlock = 1'b0;
        step();
    endtask

    task automatic test_unlock();
        Err = 1'b1;
        step();
        Err = 1'b0;
        step();
        step();
        step();
        tests++;
        if (err_cnt !== 4'd1) begin
            fails++;
            $display("FAIL pre_unlock_cnt: got %0d want 1", err_cnt);
        end
        Unlock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (led_unlock !== (i < 4)) begin
                fails++;
                $display("FAIL unlock_hold[%0d]: got %b want %b", i, led_unlock, i < 4);
            end
            if (i == 0) begin
                tests++;
                if (err_cnt !== 4'd0) begin
                    fails++;
                    $display("FAIL unlock_clear: got %0d want 0", err_cnt);
                end
            end
        end
        Unlock = 1'b0;
        step();
    endtask

    task automatic test_err();
        bit found;
        for (int k = 1; k <= 3; k++) begin
            Err = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                tests++;
                if (led_err !== (i < 3)) begin
                    fails++;
                    $display("FAIL err_hold[%0d.%0d]: got %b want %b", k, i, led_err, i < 3);
                end
                if (i == 0) begin
                    tests++;
                    if (err_cnt !== 4'(k)) begin
                        fails++;
                        $display("FAIL err_count[%0d]: got %0d want %0d", k, err_cnt, k);
                    end
                end
            end
            Err = 1'b0;
            step();
        end
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            tests++;
            if (an !== 2'b01 && an !== 2'b10) begin
                fails++;
                $display("FAIL an_onehot: got %b", an);
            end
            if (an === 2'b01) found = 1'b1;
            else step();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL scan_cnt_digit: an stuck at %b want 01", an);
        end else if (seg !== 7'h4F) begin
            fails++;
            $display("FAIL seg_cnt3: got %h want 4f", seg);
        end
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (an === 2'b10) found = 1'b1;
            else step();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL scan_lock_digit: an stuck at %b want 10", an);
        end else if (seg !== 7'h5A) begin
            fails++;
            $display("FAIL seg_digits: got %h want 5a", seg);
        end
    endtask

    task automatic test_alarm();
        logic exp;
        alert = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp = (((i / 2) % 2) == 0);
            tests++;
            if (buzzer !== exp || led_err !== exp || led_unlock !== 1'b0) begin
                fails++;
                $display("FAIL alarm_blink[%0d]: buz=%b err=%b unl=%b want %b,%b,0",
                         i, buzzer, led_err, led_unlock, exp, exp);
            end
        end
        alert  = 1'b0;
        Unlock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (led_unlock !== (i < 4) || buzzer !== 1'b0) begin
                fails++;
                $display("FAIL alarm_exit_open[%0d]: unl=%b buz=%b want %b,0",
                         i, led_unlock, buzzer, i < 4);
            end
        end
        Unlock = 1'b0;
        step();
    endtask

    task automatic test_same_edge();
        Err = 1'b1;
        step();
        Err = 1'b0;
        step();
        step();
        step();
        tests++;
        if (err_cnt !== 4'd1) begin
            fails++;
            $display("FAIL same_pre_cnt: got %0d want 1", err_cnt);
        end
        Unlock = 1'b1;
        Err    = 1'b1;
        step();
        tests++;
        if (led_unlock !== 1'b1 || led_err !== 1'b0 || err_cnt !== 4'd0) begin
            fails++;
            $display("FAIL same_edge: unl=%b err=%b cnt=%0d want 1,0,0",
                     led_unlock, led_err, err_cnt);
        end
        Unlock = 1'b0;
        Err    = 1'b0;
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_saturate();
        for (int k = 1; k <= 10; k++) begin
            Err = 1'b1;
            step();
            tests++;
            if (err_cnt !== ((k > 9) ? 4'd9 : 4'(k))) begin
                fails++;
                $display("FAIL sat_count[%0d]: got %0d want %0d", k, err_cnt, (k > 9) ? 9 : k);
            end
            Err = 1'b0;
            step();
        end
        tests++;
        if (led_err !== 1'b1) begin
            fails++;
            $display("FAIL mid_fault: got %b want 1", led_err);
        end
        #2;
        RST = 1'b1;
        #1;
        tests++;
        if (led_err !== 1'b0 || err_cnt !== 4'd0 || an !== 2'b10) begin
            fails++;
            $display("FAIL async_reset: err=%b cnt=%0d an=%b want 0,0,10",
                     led_err, err_cnt, an);
        end
        step();
        RST = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_unlock();
        test_err();
        test_alarm();
        test_same_edge();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
